// File: rtl/imm_pkg.sv
// Shared immediate-format definitions and the pure decode function used by
// both the registered pipeline and the combinational extender.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_J     = 3'd3,
    IMM_U     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_src_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  // Returns {err, imm[63:0]}; callers with xlen=32 keep only the low word.
  function automatic logic [64:0] imm_decode(input logic [31:0] instr,
                                             input imm_src_t    src,
                                             input int          xlen);
    logic [63:0] imm;
    logic        err;
    imm = '0;
    err = 1'b0;
    case (src)
      IMM_I:     imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:     imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:     imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:     imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_SHAMT: begin
        // A 6-bit shift amount is only meaningful on a 64-bit datapath.
        if (xlen == XLEN_32) begin
          if (instr[25]) err = 1'b1;
          else           imm = {59'b0, instr[24:20]};
        end else begin
          imm = {58'b0, instr[25:20]};
        end
      end
      IMM_ZIMM:  imm = {59'b0, instr[19:15]};
      default:   err = 1'b1;
    endcase
    return {err, imm};
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry skid buffer: main register drives the output, skid register
// absorbs one extra accepted entry while the consumer stalls.
module skid_buf
  import imm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output buf_state_t   state
);

  // Handshake: an entry moves when valid and ready are both high at the
  // rising edge; ready is a decode of state only, valid holds until taken.
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         acc;
  logic         xfer;

  assign acc      = in_valid && (state != BUF_TWO);
  assign xfer     = out_ready && (state != BUF_EMPTY);
  assign out_data = main_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= BUF_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (acc) begin
            main_q <= in_data;
            state  <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (acc && xfer) begin
            main_q <= in_data;
          end else if (acc) begin
            skid_q <= in_data;
            state  <= BUF_TWO;
          end else if (xfer) begin
            state  <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (xfer) begin
            main_q <= skid_q;
            state  <= BUF_ONE;
          end
        end
        default: state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered, handshaked immediate generator: decode in front of a skid
// buffer carrying {err, imm, tag}.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       imm_src_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_ext_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o
);

  localparam int W = 1 + XLEN + TAG_W;

  logic [64:0]  dec;
  logic [W-1:0] in_data;
  logic [W-1:0] out_data;
  buf_state_t   buf_state;

  assign dec     = imm_decode(instr_i, imm_src_t'(imm_src_i), XLEN);
  assign in_data = {dec[64], dec[XLEN-1:0], tag_i};

  generate
    if (XLEN == 32) begin : g_x32
      logic unused_hi;
      assign unused_hi = ^dec[63:32];
    end
  endgenerate

  skid_buf #(.W(W)) u_buf (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .in_valid  (in_valid_i),
    .in_data   (in_data),
    .out_ready (out_ready_i),
    .out_data  (out_data),
    .state     (buf_state)
  );

  assign in_ready_o  = (buf_state != BUF_TWO);
  assign out_valid_o = (buf_state != BUF_EMPTY);
  assign {err_o, imm_ext_o, tag_o} = out_data;

endmodule
